// File: rtl/regfile_param.sv
// regfile_param: parametrised integer register file for the RV32I datapath.
// There are two combinational read ports and one synchronous write port.
// Register contents are zeroed in hardware, one register per cycle. This
// happens after reset and on a clr_req pulse. While the clear runs, busy is
// high, writes are dropped and both read ports return zero.
//
// Parameters:
//   XLEN     data width of each register
//   NREGS    number of registers (power of two, >= 2)
//   AW       address width, log2(NREGS)
//   ZERO_REG 1: register 0 reads as zero and ignores writes
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   clr_req      one-cycle request for a full clear (taken only when idle)
//   busy         clear sequence in progress
//   WE/AddD/DataD  write port
//   AddA/DataA   read port A (combinational)
//   AddB/DataB   read port B (combinational)
//
// Optional build macro: REGFILE_BYPASS_EN
//   When defined, a legal same-cycle write to the address being read is
//   forwarded to that read port.

module regfile_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_req,
  output logic            busy,
  input  logic            WE,
  input  logic [AW-1:0]   AddD,
  input  logic [XLEN-1:0] DataD,
  input  logic [AW-1:0]   AddA,
  output logic [XLEN-1:0] DataA,
  input  logic [AW-1:0]   AddB,
  output logic [XLEN-1:0] DataB
);

  typedef enum logic {CLEAR, READY} state_t;

  // Register 0 is skipped by the clear when it is hardwired to zero.
  localparam logic [AW-1:0] FIRST = (ZERO_REG != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

  state_t          state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic [XLEN-1:0] xreg [NREGS];
  logic            wr_en;

  assign wr_en = (state == READY) && WE && !((ZERO_REG != 0) && (AddD == '0));

  // rst is ORed in so that busy is already high in the reset cycle itself,
  // before the state register has been loaded.
  assign busy = rst || (state != READY);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      CLEAR: begin
        idx_nxt = idx + AW'(1);
        if (idx == LAST) state_nxt = READY;
      end
      READY: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          idx_nxt   = FIRST;
        end
      end
      default: begin
        state_nxt = CLEAR;
        idx_nxt   = FIRST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      idx   <= FIRST;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // A write accepted on the edge that also takes clr_req lands in the array.
  // The clear that follows then zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) xreg[idx] <= '0;
      else if (wr_en)     xreg[AddD] <= DataD;
    end
  end

  // Read priority: busy gating first, then hardwired x0, then forwarding.
  always_comb begin
    DataA = xreg[AddA];
    if (busy) begin
      DataA = '0;
    end else if ((ZERO_REG != 0) && (AddA == '0)) begin
      DataA = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en && (AddA == AddD)) begin
      DataA = DataD;
    end
`else
`endif
  end

  always_comb begin
    DataB = xreg[AddB];
    if (busy) begin
      DataB = '0;
    end else if ((ZERO_REG != 0) && (AddB == '0)) begin
      DataB = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en && (AddB == AddD)) begin
      DataB = DataD;
    end
`else
`endif
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: self-checking bench for regfile_param.
// Two instances share all inputs. dut has ZERO_REG=1 and dut0 has ZERO_REG=0,
// so both x0 behaviours and both clear lengths run in one pass.

module tb_regfile_param;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, clr_req, WE;
  logic [AW-1:0]   AddD, AddA, AddB;
  logic [XLEN-1:0] DataD;
  logic            busy, busy0;
  logic [XLEN-1:0] DataA, DataB, DataA0, DataB0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .WE(WE), .AddD(AddD), .DataD(DataD),
    .AddA(AddA), .DataA(DataA), .AddB(AddB), .DataB(DataB)
  );

  regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
    .WE(WE), .AddD(AddD), .DataD(DataD),
    .AddA(AddA), .DataA(DataA0), .AddB(AddB), .DataB(DataB0)
  );

  typedef struct {
    string       name;
    logic [31:0] a, b, a0, b0;
  } exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  addd;
    logic [31:0] datad;
    logic [4:0]  adda, addb;
    logic [31:0] a, b, a0, b0;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1. The task drives the inputs and queues the expected
  // reads. It then compares them at the negedge and returns at the next
  // posedge+1.
  task automatic drive_read(input string name, input logic we, input logic [4:0] addd,
                            input logic [31:0] datad, input logic [4:0] adda,
                            input logic [4:0] addb, input logic [31:0] ea,
                            input logic [31:0] eb, input logic [31:0] ea0,
                            input logic [31:0] eb0);
    exp_t e;
    WE = we; AddD = addd; DataD = datad; AddA = adda; AddB = addb;
    sb.push_back('{name, ea, eb, ea0, eb0});
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, ".A"},  DataA,  e.a);
    check({e.name, ".B"},  DataB,  e.b);
    check({e.name, ".A0"}, DataA0, e.a0);
    check({e.name, ".B0"}, DataB0, e.b0);
    @(posedge clk); #1;
    WE = 1'b0;
  endtask

  // Called at posedge+1, just after the edge that starts a clear. The task
  // counts the negedges at which each instance is still busy. With disturb
  // set, it drives writes and a repeat clr_req while both instances are busy.
  task automatic count_busy(input bit disturb, output int n, output int n0);
    n = 0; n0 = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy)  n++;
      if (busy0) n0++;
      if (!busy && !busy0) break;
      if (disturb && k == 2) check("busy_read_gated", DataA, 32'h0);
      WE      = disturb && busy && busy0;
      AddD    = AW'(k);
      DataD   = 32'hBAD0_0000 | k;
      AddA    = 5'd3;
      clr_req = disturb && (k == 5);
    end
    WE = 1'b0; clr_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < NREGS; i++)
      drive_read(name, 1'b0, 5'd0, 32'h0, AW'(i), AW'(NREGS - 1 - i), 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    int n, n0;

    // The table starts from an all-zero file, with both instances READY.
    vecs[0] = '{"wr5_same",  1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,
                BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0,
                BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0};
    vecs[1] = '{"rd5",       1'b0, 5'd0,  32'h0, 5'd5, 5'd5,
                32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{"wr0_same",  1'b1, 5'd0,  32'h12345678, 5'd0, 5'd5,
                32'h0, 32'hDEADBEEF, BYP ? 32'h12345678 : 32'h0, 32'hDEADBEEF};
    vecs[3] = '{"rd0",       1'b0, 5'd0,  32'h0, 5'd0, 5'd0,
                32'h0, 32'h0, 32'h12345678, 32'h12345678};
    vecs[4] = '{"wr7_one",   1'b1, 5'd7,  32'h1, 5'd7, 5'd0,
                BYP ? 32'h1 : 32'h0, 32'h0, BYP ? 32'h1 : 32'h0, 32'h12345678};
    vecs[5] = '{"wr7_a5",    1'b1, 5'd7,  32'hA5A5A5A5, 5'd7, 5'd5,
                BYP ? 32'hA5A5A5A5 : 32'h1, 32'hDEADBEEF,
                BYP ? 32'hA5A5A5A5 : 32'h1, 32'hDEADBEEF};
    vecs[6] = '{"rd7",       1'b0, 5'd0,  32'h0, 5'd7, 5'd7,
                32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[7] = '{"wr31_same", 1'b1, 5'd31, 32'hFFFFFFFF, 5'd30, 5'd31,
                32'h0, BYP ? 32'hFFFFFFFF : 32'h0, 32'h0, BYP ? 32'hFFFFFFFF : 32'h0};
    vecs[8] = '{"rd31",      1'b0, 5'd0,  32'h0, 5'd31, 5'd1,
                32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0};

    rst = 1'b1; clr_req = 1'b0; WE = 1'b0; AddD = '0; DataD = '0; AddA = 5'd5; AddB = 5'd9;

    // Test 1: reset, then the initial clear.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   {31'h0, busy},  32'h1);
    check("rst_busy0",  {31'h0, busy0}, 32'h1);
    check("rst_DataA",  DataA,  32'h0);
    check("rst_DataB0", DataB0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(1'b0, n, n0);
    check("init_clear_cycles",  n,  32'd31);
    check("init_clear_cycles0", n0, 32'd32);
    read_all_zero("init_zero");

    // Tests 2-4: table of writes and reads.
    for (int v = 0; v < 9; v++)
      drive_read(vecs[v].name, vecs[v].we, vecs[v].addd, vecs[v].datad, vecs[v].adda,
                 vecs[v].addb, vecs[v].a, vecs[v].b, vecs[v].a0, vecs[v].b0);

    // Test 5: fill, then clear together with a write. Writes and a repeat
    // clr_req arrive while busy.
    for (int i = 1; i < NREGS; i++) begin
      WE = 1'b1; AddD = AW'(i); DataD = 32'hC0DE_0000 | i;
      @(posedge clk); #1;
    end
    WE = 1'b0;
    drive_read("fill", 1'b0, 5'd0, 32'h0, 5'd3, 5'd31,
               32'hC0DE0003, 32'hC0DE001F, 32'hC0DE0003, 32'hC0DE001F);
    clr_req = 1'b1; WE = 1'b1; AddD = 5'd3; DataD = 32'hEEEEEEEE;
    @(posedge clk); #1;
    clr_req = 1'b0; WE = 1'b0;
    count_busy(1'b1, n, n0);
    check("req_clear_cycles",  n,  32'd31);
    check("req_clear_cycles0", n0, 32'd32);
    read_all_zero("req_zero");

    // Test 6: rst during a clear restarts the sequence.
    drive_read("pre6", 1'b1, 5'd9, 32'h99, 5'd9, 5'd9, BYP ? 32'h99 : 32'h0,
               BYP ? 32'h99 : 32'h0, BYP ? 32'h99 : 32'h0, BYP ? 32'h99 : 32'h0);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(1'b0, n, n0);
    check("midrst_clear_cycles",  n,  32'd31);
    check("midrst_clear_cycles0", n0, 32'd32);
    read_all_zero("midrst_zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
